// File: rtl/interrupt_controller.sv
// Fixed-priority interrupt controller: latches peripheral factor flags, applies per-group masks,
// and hands the highest-priority pending vector to the CPU through a REQ/SERVICE handshake.
module interrupt_controller #(
  parameter int NUM_GROUPS = 6
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] set_clock,
  input  logic [1:0] set_stopwatch,
  input  logic       set_k0,
  input  logic       set_k1,
  input  logic       set_serial,
  input  logic       prog_factor,
  output logic       prog_reset_factor,
  input  logic       mask_we,
  input  logic [2:0] mask_group,
  input  logic [3:0] mask_data,
  input  logic       factor_re,
  input  logic [2:0] factor_group,
  output logic [3:0] factor_rdata,
  input  logic       int_enable,
  output logic       irq,
  output logic [3:0] irq_vector,
  input  logic       irq_ack,
  input  logic       irq_done
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } state_t;

  localparam logic [3:0] GRP_LIMIT = 4'(NUM_GROUPS);
  // Element 0 is the clock timer group, element 5 the prog timer group.
  localparam logic [5:0][3:0] WIDTH_MASK = {4'h1, 4'h1, 4'h1, 4'h1, 4'h3, 4'hF};

  state_t          state_r, next_state_s;
  logic [5:0][3:0] factor_r;
  logic [5:0][3:0] mask_r;
  logic [5:0][3:0] set_s;
  logic [5:0]      pend_s;
  logic [3:0]      win_vec_s;
  logic [3:0]      rdata_sel_s;
  logic            any_pend_s;
  logic            prog_factor_r;
  logic            mask_ok_s;
  logic            read_ok_s;
  logic            irq_r;
  logic [3:0]      irq_vector_r;
  logic [3:0]      factor_rdata_r;
  logic            prog_reset_factor_r;

  assign mask_ok_s = ({1'b0, mask_group} < GRP_LIMIT);
  assign read_ok_s = ({1'b0, factor_group} < GRP_LIMIT);

  // Gather set sources; prog timer sets on the rising edge of its level flag.
  always_comb begin
    set_s    = '0;
    set_s[0] = set_clock;
    set_s[1] = {2'b00, set_stopwatch};
    set_s[2] = {3'b000, set_k0};
    set_s[3] = {3'b000, set_k1};
    set_s[4] = {3'b000, set_serial};
    set_s[5] = {3'b000, prog_factor & ~prog_factor_r};
  end

  // Factor latches: a read clears the group, but a same-cycle set survives the clear.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      factor_r      <= '0;
      prog_factor_r <= 1'b0;
    end else begin
      prog_factor_r <= prog_factor;
      for (int g = 0; g < 6; g++) begin
        if (factor_re && read_ok_s && (factor_group == 3'(g))) begin
          factor_r[g] <= set_s[g] & WIDTH_MASK[g];
        end else begin
          factor_r[g] <= (factor_r[g] | set_s[g]) & WIDTH_MASK[g];
        end
      end
    end
  end

  // Mask registers; out-of-range group indices never match.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      mask_r <= '0;
    end else begin
      for (int g = 0; g < 6; g++) begin
        if (mask_we && mask_ok_s && (mask_group == 3'(g))) begin
          mask_r[g] <= mask_data & WIDTH_MASK[g];
        end else begin
          mask_r[g] <= mask_r[g];
        end
      end
    end
  end

  // Pending groups and the fixed-priority winner (group 5 highest).
  always_comb begin
    for (int g = 0; g < 6; g++) begin
      pend_s[g] = |(factor_r[g] & mask_r[g]);
    end
    any_pend_s = |pend_s;
    casez (pend_s)
      6'b1?????: win_vec_s = 4'hC;
      6'b01????: win_vec_s = 4'hA;
      6'b001???: win_vec_s = 4'h8;
      6'b0001??: win_vec_s = 4'h6;
      6'b00001?: win_vec_s = 4'h4;
      6'b000001: win_vec_s = 4'h2;
      default:   win_vec_s = 4'h0;
    endcase
  end

  // Read data selection.
  always_comb begin
    case (factor_group)
      3'd0:    rdata_sel_s = factor_r[0];
      3'd1:    rdata_sel_s = factor_r[1];
      3'd2:    rdata_sel_s = factor_r[2];
      3'd3:    rdata_sel_s = factor_r[3];
      3'd4:    rdata_sel_s = factor_r[4];
      3'd5:    rdata_sel_s = factor_r[5];
      default: rdata_sel_s = 4'h0;
    endcase
  end

  // Next-state logic; an ack outranks a simultaneous loss of pending.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (int_enable && any_pend_s) next_state_s = ST_REQ;
        else                          next_state_s = ST_IDLE;
      end
      ST_REQ: begin
        if (irq_ack)                         next_state_s = ST_SERVICE;
        else if (!any_pend_s || !int_enable) next_state_s = ST_IDLE;
        else                                 next_state_s = ST_REQ;
      end
      ST_SERVICE: begin
        if (irq_done) next_state_s = ST_IDLE;
        else          next_state_s = ST_SERVICE;
      end
      default: next_state_s = ST_IDLE;
    endcase
  end

  // State and registered CPU-side outputs; the vector freezes whenever REQ is not next.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r      <= ST_IDLE;
      irq_r        <= 1'b0;
      irq_vector_r <= 4'h0;
    end else begin
      state_r <= next_state_s;
      irq_r   <= (next_state_s == ST_REQ);
      if (next_state_s == ST_REQ) irq_vector_r <= win_vec_s;
      else                        irq_vector_r <= irq_vector_r;
    end
  end

  // Registered read data and the prog timer clear strobe.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      factor_rdata_r      <= 4'h0;
      prog_reset_factor_r <= 1'b0;
    end else begin
      prog_reset_factor_r <= factor_re && (factor_group == 3'd5);
      if (factor_re) factor_rdata_r <= read_ok_s ? rdata_sel_s : 4'h0;
      else           factor_rdata_r <= factor_rdata_r;
    end
  end

  assign irq               = irq_r;
  assign irq_vector        = irq_vector_r;
  assign factor_rdata      = factor_rdata_r;
  assign prog_reset_factor = prog_reset_factor_r;

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed bench for interrupt_controller: a per-cycle behavioural model checked on every
// falling edge, plus hand-computed literal expectations at key points of each scenario.
module tb_interrupt_controller;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] set_clock;
  logic [1:0] set_stopwatch;
  logic       set_k0, set_k1, set_serial, prog_factor;
  logic       prog_reset_factor;
  logic       mask_we;
  logic [2:0] mask_group;
  logic [3:0] mask_data;
  logic       factor_re;
  logic [2:0] factor_group;
  logic [3:0] factor_rdata;
  logic       int_enable;
  logic       irq;
  logic [3:0] irq_vector;
  logic       irq_ack, irq_done;

  int n_vec = 0;
  int n_err = 0;
  bit check_en = 1'b0;

  interrupt_controller #(.NUM_GROUPS(6)) dut (
    .clk(clk), .reset_n(reset_n),
    .set_clock(set_clock), .set_stopwatch(set_stopwatch),
    .set_k0(set_k0), .set_k1(set_k1), .set_serial(set_serial),
    .prog_factor(prog_factor), .prog_reset_factor(prog_reset_factor),
    .mask_we(mask_we), .mask_group(mask_group), .mask_data(mask_data),
    .factor_re(factor_re), .factor_group(factor_group), .factor_rdata(factor_rdata),
    .int_enable(int_enable), .irq(irq), .irq_vector(irq_vector),
    .irq_ack(irq_ack), .irq_done(irq_done)
  );

  always #5 clk = ~clk;

  // Behavioural model: per-group integer factors/masks and a three-mode handshake.
  int wmask[6] = '{15, 3, 1, 1, 1, 1};
  int vecs[6]  = '{2, 4, 6, 8, 10, 12};
  int m_fac[6];
  int m_mask[6];
  int m_mode;            // 0 idle, 1 requesting, 2 in service
  int m_prev_prog;
  int m_irq, m_vec, m_rdata, m_strobe;

  task automatic model_step();
    int best;
    int s[6];
    best = -1;
    for (int g = 0; g < 6; g++)
      if ((m_fac[g] & m_mask[g]) != 0) best = g;
    s[0] = int'(set_clock);
    s[1] = int'(set_stopwatch);
    s[2] = int'(set_k0);
    s[3] = int'(set_k1);
    s[4] = int'(set_serial);
    s[5] = (prog_factor && m_prev_prog == 0) ? 1 : 0;
    if (!reset_n) begin
      for (int g = 0; g < 6; g++) begin m_fac[g] = 0; m_mask[g] = 0; end
      m_mode = 0; m_prev_prog = 0;
      m_irq = 0; m_vec = 0; m_rdata = 0; m_strobe = 0;
      return;
    end
    if (m_mode == 0) begin
      if (int_enable && best >= 0) m_mode = 1;
    end else if (m_mode == 1) begin
      if (irq_ack) m_mode = 2;
      else if (best < 0 || !int_enable) m_mode = 0;
    end else begin
      if (irq_done) m_mode = 0;
    end
    m_irq = (m_mode == 1) ? 1 : 0;
    if (m_mode == 1) m_vec = vecs[best];
    m_strobe = 0;
    if (factor_re) begin
      if (factor_group < 3'd6) begin
        m_rdata = m_fac[factor_group];
        m_fac[factor_group] = 0;
        m_strobe = (factor_group == 3'd5) ? 1 : 0;
      end else begin
        m_rdata = 0;
      end
    end
    if (mask_we && mask_group < 3'd6) m_mask[mask_group] = int'(mask_data) & wmask[mask_group];
    for (int g = 0; g < 6; g++) m_fac[g] = m_fac[g] | (s[g] & wmask[g]);
    m_prev_prog = prog_factor ? 1 : 0;
  endtask

  always @(posedge clk) model_step();

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Compare every output against the model on each falling edge.
  always @(negedge clk) begin
    if (check_en) begin
      check("model_irq", {31'd0, irq}, m_irq);
      check("model_vector", {28'd0, irq_vector}, m_vec);
      check("model_rdata", {28'd0, factor_rdata}, m_rdata);
      check("model_strobe", {31'd0, prog_reset_factor}, m_strobe);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    check_en = 1'b1;
    set_clock = 4'h0; set_stopwatch = 2'b00; set_k0 = 1'b0; set_k1 = 1'b0; set_serial = 1'b0;
    mask_we = 1'b0; factor_re = 1'b0; irq_ack = 1'b0; irq_done = 1'b0;
  endtask

  task automatic wmask_grp(input logic [2:0] g, input logic [3:0] d);
    mask_we = 1'b1; mask_group = g; mask_data = d;
    tick();
  endtask

  task automatic read_grp(input logic [2:0] g);
    factor_re = 1'b1; factor_group = g;
    tick();
  endtask

  initial begin
    reset_n = 1'b0; prog_factor = 1'b0; int_enable = 1'b0;
    set_clock = 4'h0; set_stopwatch = 2'b00; set_k0 = 1'b0; set_k1 = 1'b0; set_serial = 1'b0;
    mask_we = 1'b0; mask_group = 3'd0; mask_data = 4'h0;
    factor_re = 1'b0; factor_group = 3'd0; irq_ack = 1'b0; irq_done = 1'b0;
    tick(); tick();
    check("reset_irq", {31'd0, irq}, 32'd0);
    check("reset_vector", {28'd0, irq_vector}, 32'd0);
    check("reset_rdata", {28'd0, factor_rdata}, 32'd0);
    check("reset_strobe", {31'd0, prog_reset_factor}, 32'd0);
    reset_n = 1'b1;

    // Prog timer edge, ack, read-clear with strobe, RETI.
    wmask_grp(3'd5, 4'h1);
    int_enable = 1'b1; prog_factor = 1'b1;
    tick();
    check("prog_n1_irq", {31'd0, irq}, 32'd0);
    tick();
    check("prog_n2_irq", {31'd0, irq}, 32'd1);
    check("prog_vector", {28'd0, irq_vector}, 32'hC);
    irq_ack = 1'b1; tick();
    check("ack_irq", {31'd0, irq}, 32'd0);
    read_grp(3'd5);
    check("prog_rdata", {28'd0, factor_rdata}, 32'h1);
    check("prog_strobe", {31'd0, prog_reset_factor}, 32'd1);
    tick();
    check("prog_strobe_end", {31'd0, prog_reset_factor}, 32'd0);
    irq_done = 1'b1; tick(); tick();
    check("done_irq", {31'd0, irq}, 32'd0);
    prog_factor = 1'b0;

    // Serial outranks clock timer; clearing serial moves the vector while requesting.
    wmask_grp(3'd0, 4'hF);
    wmask_grp(3'd4, 4'h1);
    set_clock = 4'b0100; set_serial = 1'b1; tick(); tick();
    check("serial_vector", {28'd0, irq_vector}, 32'hA);
    read_grp(3'd4); tick();
    check("fallback_irq", {31'd0, irq}, 32'd1);
    check("fallback_vector", {28'd0, irq_vector}, 32'h2);
    irq_ack = 1'b1; tick();
    read_grp(3'd0);
    check("clock_rdata", {28'd0, factor_rdata}, 32'h4);
    irq_done = 1'b1; tick(); tick();

    // Masked factor never raises irq, even after the mask opens post-clear.
    wmask_grp(3'd0, 4'h0);
    set_clock = 4'b0010; tick(); tick();
    check("masked_irq", {31'd0, irq}, 32'd0);
    read_grp(3'd0);
    check("masked_rdata", {28'd0, factor_rdata}, 32'h2);
    wmask_grp(3'd0, 4'hF); tick();
    check("cleared_irq", {31'd0, irq}, 32'd0);

    // Same-cycle set beats read-clear.
    set_stopwatch = 2'b10; tick();
    set_stopwatch = 2'b01; read_grp(3'd1);
    check("race_rdata", {28'd0, factor_rdata}, 32'h2);
    read_grp(3'd1);
    check("race_residue", {28'd0, factor_rdata}, 32'h1);

    // int_enable gating.
    int_enable = 1'b0;
    wmask_grp(3'd3, 4'h1);
    set_k1 = 1'b1; tick(); tick(); tick();
    check("disabled_irq", {31'd0, irq}, 32'd0);
    int_enable = 1'b1; tick();
    check("enabled_irq", {31'd0, irq}, 32'd1);
    check("k1_vector", {28'd0, irq_vector}, 32'h8);
    int_enable = 1'b0; tick();
    check("drop_irq", {31'd0, irq}, 32'd0);
    read_grp(3'd3);
    check("k1_kept", {28'd0, factor_rdata}, 32'h1);

    // Reset in SERVICE, then out-of-range group accesses.
    int_enable = 1'b1; set_k1 = 1'b1; tick(); tick();
    irq_ack = 1'b1; tick();
    set_clock = 4'hF; tick();
    irq_ack = 1'b1; tick();
    check("svc_ack_ignored", {31'd0, irq}, 32'd0);
    reset_n = 1'b0; tick();
    check("rst_irq", {31'd0, irq}, 32'd0);
    check("rst_vector", {28'd0, irq_vector}, 32'd0);
    reset_n = 1'b1;
    read_grp(3'd0);
    check("rst_factors", {28'd0, factor_rdata}, 32'h0);
    set_k1 = 1'b1; tick(); tick(); tick();
    check("rst_masks", {31'd0, irq}, 32'd0);
    irq_ack = 1'b1; tick();
    wmask_grp(3'd7, 4'hF);
    set_clock = 4'b1000; tick();
    read_grp(3'd0);
    check("pre_oob_rdata", {28'd0, factor_rdata}, 32'h8);
    read_grp(3'd7);
    check("oob_rdata", {28'd0, factor_rdata}, 32'h0);
    check("oob_strobe", {31'd0, prog_reset_factor}, 32'd0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
